// File: rtl/turfio_phy_bringup_ctrl.sv
// Bring-up sequencer for the TURFIO native-mode PHY: drives RST / EN_VTC / START_BITSLIP,
// waits on each PHY ready indication with a per-state timeout, and retries a bounded number of times.
module turfio_phy_bringup_ctrl #(
    parameter int NUM_NIBBLES     = 3,
    parameter int RST_HOLD_CYCLES = 64,
    parameter int TIMEOUT_CYCLES  = 100000,
    parameter int MAX_RETRIES     = 7
) (
    input  logic                   init_clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   pll_locked,
    input  logic                   rst_seq_done,
    input  logic [NUM_NIBBLES-1:0] dly_rdy,
    input  logic [NUM_NIBBLES-1:0] vtc_rdy,
    input  logic                   bitslip_done,
    input  logic                   fifo_data_valid,
    output logic                   phy_rst,
    output logic [NUM_NIBBLES-1:0] en_vtc,
    output logic                   start_bitslip,
    output logic                   ready,
    output logic                   error,
    output logic [3:0]             state_o,
    output logic [7:0]             retry_count
);
    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_PHY_RST     = 4'd1,
        ST_WAIT_LOCK   = 4'd2,
        ST_WAIT_RSTSEQ = 4'd3,
        ST_WAIT_DLY    = 4'd4,
        ST_WAIT_VTC    = 4'd5,
        ST_BITSLIP     = 4'd6,
        ST_WAIT_VALID  = 4'd7,
        ST_RUN         = 4'd8,
        ST_FAIL        = 4'd9
    } state_t;

    localparam int             SYNC_W       = 2 * NUM_NIBBLES + 4;
    localparam logic [16:0]    RST_LAST     = 17'(RST_HOLD_CYCLES - 1);
    localparam logic [16:0]    TIMEOUT_LAST = 17'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]     RETRY_LIMIT  = 8'(MAX_RETRIES);

    logic [SYNC_W-1:0] async_vec;
    logic [SYNC_W-1:0] sync_vec;

    assign async_vec = {pll_locked, rst_seq_done, bitslip_done, fifo_data_valid, vtc_rdy, dly_rdy};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_W; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge init_clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= async_vec[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_vec[gi] = sync_reg;
        end
    endgenerate

    // Ready vectors only count once every nibble reports, so per-bit sync skew cannot cause an early exit.
    logic dly_ok_s, vtc_ok_s, fifo_valid_s, bitslip_done_s, rst_seq_done_s, pll_locked_s;
    assign dly_ok_s       = &sync_vec[NUM_NIBBLES-1:0];
    assign vtc_ok_s       = &sync_vec[2*NUM_NIBBLES-1:NUM_NIBBLES];
    assign fifo_valid_s   = sync_vec[2*NUM_NIBBLES];
    assign bitslip_done_s = sync_vec[2*NUM_NIBBLES+1];
    assign rst_seq_done_s = sync_vec[2*NUM_NIBBLES+2];
    assign pll_locked_s   = sync_vec[2*NUM_NIBBLES+3];

    state_t      state_reg, state_next, succ_state;
    logic [16:0] cnt_reg, cnt_next;
    logic [7:0]  retry_reg, retry_next;
    logic        phy_rst_reg, phy_rst_next;
    logic        en_vtc_reg, en_vtc_next;
    logic        start_bitslip_reg, start_bitslip_next;
    logic        ready_reg, ready_next;
    logic        error_reg, error_next;
    logic        in_wait, wait_exit, retry_req;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        retry_next = retry_reg;
        succ_state = state_reg;
        in_wait    = 1'b0;
        wait_exit  = 1'b0;
        retry_req  = 1'b0;

        case (state_reg)
            ST_IDLE:        state_next = ST_PHY_RST;
            ST_PHY_RST:     if (cnt_reg == RST_LAST) state_next = ST_WAIT_LOCK;
            ST_WAIT_LOCK:   begin in_wait = 1'b1; wait_exit = pll_locked_s;   succ_state = ST_WAIT_RSTSEQ; end
            ST_WAIT_RSTSEQ: begin in_wait = 1'b1; wait_exit = rst_seq_done_s; succ_state = ST_WAIT_DLY;    end
            ST_WAIT_DLY:    begin in_wait = 1'b1; wait_exit = dly_ok_s;       succ_state = ST_WAIT_VTC;    end
            ST_WAIT_VTC:    begin in_wait = 1'b1; wait_exit = vtc_ok_s;       succ_state = ST_BITSLIP;     end
            ST_BITSLIP:     begin in_wait = 1'b1; wait_exit = bitslip_done_s; succ_state = ST_WAIT_VALID;  end
            ST_WAIT_VALID:  begin in_wait = 1'b1; wait_exit = fifo_valid_s;   succ_state = ST_RUN;         end
            ST_RUN:         retry_req = ~pll_locked_s | ~fifo_valid_s;
            default:        ;
        endcase

        // An exit condition arriving in the expiry cycle still wins over the timeout.
        if (in_wait) begin
            if (wait_exit) begin
                state_next = succ_state;
            end else if (cnt_reg == TIMEOUT_LAST) begin
                retry_req = 1'b1;
            end
        end

        if (retry_req) begin
            if (retry_reg < RETRY_LIMIT) begin
                retry_next = (retry_reg == 8'hFF) ? retry_reg : retry_reg + 8'd1;
                state_next = ST_PHY_RST;
            end else begin
                state_next = ST_FAIL;
            end
        end

        if (!enable) begin
            state_next = ST_IDLE;
            retry_next = '0;
        end

        if (state_next != state_reg) begin
            cnt_next = '0;
        end else if (in_wait || state_reg == ST_PHY_RST) begin
            cnt_next = cnt_reg + 17'd1;
        end

        // Outputs are decoded from the next state so they move on the same edge as state_o.
        phy_rst_next       = state_next inside {ST_IDLE, ST_PHY_RST, ST_WAIT_LOCK, ST_FAIL};
        en_vtc_next        = state_next inside {ST_WAIT_VTC, ST_BITSLIP, ST_WAIT_VALID, ST_RUN};
        start_bitslip_next = (state_next == ST_BITSLIP);
        ready_next         = (state_next == ST_RUN);
        error_next         = (state_next == ST_FAIL);
    end

    always_ff @(posedge init_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_IDLE;
            cnt_reg           <= '0;
            retry_reg         <= '0;
            phy_rst_reg       <= 1'b1;
            en_vtc_reg        <= 1'b0;
            start_bitslip_reg <= 1'b0;
            ready_reg         <= 1'b0;
            error_reg         <= 1'b0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            retry_reg         <= retry_next;
            phy_rst_reg       <= phy_rst_next;
            en_vtc_reg        <= en_vtc_next;
            start_bitslip_reg <= start_bitslip_next;
            ready_reg         <= ready_next;
            error_reg         <= error_next;
        end
    end

    assign phy_rst       = phy_rst_reg;
    assign en_vtc        = {NUM_NIBBLES{en_vtc_reg}};
    assign start_bitslip = start_bitslip_reg;
    assign ready         = ready_reg;
    assign error         = error_reg;
    assign state_o       = state_reg;
    assign retry_count   = retry_reg;

endmodule

// File: tb/tb_turfio_phy_bringup_ctrl.sv
// Bench for turfio_phy_bringup_ctrl: table-driven nominal bring-up, directed corner sequences,
// and randomized stimulus compared every cycle against a behavioural model of the bring-up rules.
module tb_turfio_phy_bringup_ctrl;
    localparam int N     = 3;
    localparam int RHOLD = 4;
    localparam int TO    = 100;
    localparam int MAXR  = 2;

    logic         init_clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         pll_locked = 1'b0;
    logic         rst_seq_done = 1'b0;
    logic [N-1:0] dly_rdy = '0;
    logic [N-1:0] vtc_rdy = '0;
    logic         bitslip_done = 1'b0;
    logic         fifo_data_valid = 1'b0;
    logic         phy_rst;
    logic [N-1:0] en_vtc;
    logic         start_bitslip;
    logic         ready;
    logic         error;
    logic [3:0]   state_o;
    logic [7:0]   retry_count;

    int checks = 0;
    int errors = 0;

    turfio_phy_bringup_ctrl #(
        .NUM_NIBBLES(N), .RST_HOLD_CYCLES(RHOLD), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MAXR)
    ) dut (
        .init_clk(init_clk), .rst_n(rst_n), .enable(enable),
        .pll_locked(pll_locked), .rst_seq_done(rst_seq_done), .dly_rdy(dly_rdy),
        .vtc_rdy(vtc_rdy), .bitslip_done(bitslip_done), .fifo_data_valid(fifo_data_valid),
        .phy_rst(phy_rst), .en_vtc(en_vtc), .start_bitslip(start_bitslip), .ready(ready),
        .error(error), .state_o(state_o), .retry_count(retry_count)
    );

    always #5 init_clk = ~init_clk;

    // ---------------- behavioural reference ----------------
    typedef struct packed {
        logic         pll;
        logic         rsq;
        logic [N-1:0] dly;
        logic [N-1:0] vtc;
        logic         bs;
        logic         fv;
    } inp_t;

    typedef struct packed {
        int st;
        int t;
        int rc;
    } mst_t;

    inp_t inp_now, seen_d1, seen_d2;
    mst_t m;
    logic [18:0] obs;

    assign inp_now = {pll_locked, rst_seq_done, dly_rdy, vtc_rdy, bitslip_done, fifo_data_valid};
    assign obs     = {state_o, phy_rst, en_vtc, start_bitslip, ready, error, retry_count};

    // Expected control pins for a given state number: {phy_rst, en_vtc[2:0], start_bitslip, ready, error}.
    function automatic logic [6:0] outs_for(input int st);
        logic r, v;
        r = (st <= 2) || (st == 9);
        v = (st >= 5) && (st <= 8);
        return {r, {N{v}}, st == 6, st == 8, st == 9};
    endfunction

    function automatic logic [18:0] pack_exp(input int st, input int rc);
        return {4'(st), outs_for(st), 8'(rc)};
    endfunction

    // One clock of the bring-up rules; s is what the controller sees after two cycles of synchronisation.
    function automatic mst_t model_step(input mst_t cur, input logic en, input inp_t s);
        mst_t r;
        bit exit_now, fault;
        r = cur;
        r.t = cur.t + 1;
        exit_now = 0;
        fault = 0;
        if (!en) return '{default: 0};
        case (cur.st)
            0: exit_now = 1;
            1: exit_now = (cur.t == RHOLD - 1);
            2: exit_now = s.pll;
            3: exit_now = s.rsq;
            4: exit_now = &s.dly;
            5: exit_now = &s.vtc;
            6: exit_now = s.bs;
            7: exit_now = s.fv;
            8: fault = !s.pll || !s.fv;
            default: ;
        endcase
        if (cur.st >= 2 && cur.st <= 7 && !exit_now && cur.t >= TO - 1) fault = 1;
        if (exit_now) begin
            r.st = cur.st + 1;
            r.t = 0;
        end
        if (fault) begin
            r.t = 0;
            if (cur.rc < MAXR) begin
                r.rc = cur.rc + 1;
                r.st = 1;
            end else begin
                r.st = 9;
            end
        end
        return r;
    endfunction

    always @(posedge init_clk or negedge rst_n) begin
        if (!rst_n) begin
            m       <= '{default: 0};
            seen_d1 <= '0;
            seen_d2 <= '0;
        end else begin
            seen_d1 <= inp_now;
            seen_d2 <= seen_d1;
            m       <= model_step(m, enable, seen_d2);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge init_clk) check("model", 32'(obs), 32'(pack_exp(m.st, m.rc)));

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge init_clk);
        @(negedge init_clk);
    endtask

    task automatic set_lvl(input int k);
        pll_locked      = (k >= 1);
        rst_seq_done    = (k >= 2);
        dly_rdy         = (k >= 3) ? '1 : '0;
        vtc_rdy         = (k >= 4) ? '1 : '0;
        bitslip_done    = (k >= 5);
        fifo_data_valid = (k >= 6);
    endtask

    task automatic go_idle();
        enable = 1'b0;
        set_lvl(0);
        cyc(3);
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int n;
        n = 0;
        while (state_o !== s && n < budget) begin
            @(negedge init_clk);
            n++;
        end
        check(name, 32'(state_o), 32'(s));
    endtask

    typedef struct {
        logic en;
        int   lvl;
        int   ncyc;
        int   st;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish required finish by 3ms");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int n;

        // Nominal bring-up: each ready rises ~10 cycles after its state is entered.
        tbl.push_back('{1'b1, 0, 1, 1});
        tbl.push_back('{1'b1, 0, RHOLD - 1, 1});
        tbl.push_back('{1'b1, 0, 1, 2});
        for (int k = 1; k <= 6; k++) begin
            tbl.push_back('{1'b1, k - 1, 9, k + 1});
            tbl.push_back('{1'b1, k, 2, k + 1});
            tbl.push_back('{1'b1, k, 1, k + 2});
        end
        tbl.push_back('{1'b1, 6, 20, 8});
        tbl.push_back('{1'b0, 6, 1, 0});

        cyc(1);
        check("reset_outputs", 32'(obs), 32'(pack_exp(0, 0)));
        rst_n = 1'b1;
        cyc(2);
        check("idle_hold", 32'(obs), 32'(pack_exp(0, 0)));

        for (int i = 0; i < tbl.size(); i++) begin
            enable = tbl[i].en;
            set_lvl(tbl[i].lvl);
            cyc(tbl[i].ncyc);
            check($sformatf("tbl[%0d]", i), 32'(obs), 32'(pack_exp(tbl[i].st, 0)));
        end

        // Skewed dly_rdy: bits at cycles 5, 9, 30 after WAIT_DLY entry.
        go_idle();
        set_lvl(2);
        enable = 1'b1;
        wait_state(4'd4, 50, "skew_reach_dly");
        cyc(4); dly_rdy[0] = 1'b1;
        cyc(4); dly_rdy[1] = 1'b1;
        cyc(21);
        check("skew_partial_hold", 32'(state_o), 32'd4);
        dly_rdy[2] = 1'b1;
        cyc(2);
        check("skew_sync_latency", 32'(state_o), 32'd4);
        cyc(1);
        check("skew_exit_state", 32'(state_o), 32'd5);
        check("skew_en_vtc", 32'(en_vtc), 32'b111);

        // Stuck vtc_rdy: three timed-out attempts, then FAIL.
        go_idle();
        set_lvl(3);
        vtc_rdy = 3'b011;
        enable = 1'b1;
        for (int a = 0; a < 3; a++) begin
            wait_state(4'd5, 300, $sformatf("to_reach_vtc[%0d]", a));
            n = 1;
            while (state_o == 4'd5 && n < 300) begin
                cyc(1);
                n++;
            end
            check($sformatf("to_dwell[%0d]", a), 32'(n), 32'(TO + 1));
            check($sformatf("to_next_state[%0d]", a), 32'(state_o), (a < 2) ? 32'd1 : 32'd9);
            check($sformatf("to_retry_count[%0d]", a), 32'(retry_count), (a < 2) ? 32'(a + 1) : 32'd2);
        end
        check("fail_error", 32'(error), 32'd1);
        check("fail_phy_rst", 32'(phy_rst), 32'd1);
        cyc(5);
        check("fail_sticky", 32'(state_o), 32'd9);
        enable = 1'b0;
        cyc(1);
        check("fail_exit", 32'(obs), 32'(pack_exp(0, 0)));

        // Link loss in RUN: fifo_data_valid low for 5 cycles.
        go_idle();
        set_lvl(6);
        enable = 1'b1;
        wait_state(4'd8, 100, "link_reach_run");
        cyc(5);
        fifo_data_valid = 1'b0;
        cyc(2);
        check("link_ready_held", 32'(ready), 32'd1);
        cyc(1);
        check("link_ready_drop", 32'(ready), 32'd0);
        check("link_retry_state", 32'(state_o), 32'd1);
        check("link_retry_count", 32'(retry_count), 32'd1);
        cyc(2);
        fifo_data_valid = 1'b1;
        wait_state(4'd8, 200, "link_rerun");
        check("link_rerun_ready", 32'(ready), 32'd1);
        check("link_rerun_count", 32'(retry_count), 32'd1);

        // Abort in BITSLIP.
        go_idle();
        set_lvl(4);
        enable = 1'b1;
        wait_state(4'd6, 100, "abort_reach_bitslip");
        check("abort_bitslip_on", 32'(start_bitslip), 32'd1);
        cyc(3);
        enable = 1'b0;
        cyc(1);
        check("abort_idle", 32'(obs), 32'(pack_exp(0, 0)));

        // bitslip_done seen in the expiry cycle: exit wins.
        enable = 1'b1;
        wait_state(4'd6, 100, "simul_reach_bitslip");
        cyc(TO - 3);
        bitslip_done = 1'b1;
        cyc(2);
        check("simul_pre_edge", 32'(state_o), 32'd6);
        cyc(1);
        check("simul_exit", 32'(state_o), 32'd7);
        check("simul_no_retry", 32'(retry_count), 32'd0);

        // Asynchronous reset between edges in WAIT_VALID.
        cyc(5);
        check("areset_pre", 32'(state_o), 32'd7);
        #2 rst_n = 1'b0;
        #1 check("areset_outputs", 32'(obs), 32'(pack_exp(0, 0)));
        @(negedge init_clk);
        rst_n = 1'b1;

        // Randomized run against the behavioural reference.
        go_idle();
        for (int i = 0; i < 4000; i++) begin
            @(negedge init_clk);
            enable = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 9) == 0) pll_locked = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) rst_seq_done = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 9) == 0) dly_rdy[b] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 9) == 0) vtc_rdy[b] = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 9) == 0) bitslip_done = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 14) == 0) fifo_data_valid = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        cyc(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
